// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and sizing for the cache-line to DRAM-burst adaptor.
package cacheline_adaptor_pkg;
  localparam int LINE_W      = 256;
  localparam int BURST_W     = 64;
  localparam int BEATS       = LINE_W / BURST_W;
  localparam int OFFSET_BITS = 5;
  localparam int CNT_W       = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD_BURST,
    RD_DONE,
    WR_BURST,
    WR_DONE
  } state_t;
endpackage

// File: rtl/cacheline_adaptor_if.sv
// Cache-side and DRAM-side signals of the adaptor; slave is the adaptor's view.
interface cacheline_adaptor_if;
  import cacheline_adaptor_pkg::*;

  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts single cache-line read/write requests into 4-beat DRAM bursts.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input logic clk,
  input logic rst,
  cacheline_adaptor_if.slave bus
);

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [LINE_W-1:0]   rline_q;
  logic [LINE_W-1:0]   wline_q;
  logic [31:0]         addr_q;
  logic [31:0]         addr_d;
  logic                read_q;
  logic                write_q;
  logic                resp_q;

  // Line-aligned request address; the low offset bits never reach DRAM.
  always_comb begin
    addr_d = bus.address_i & ~((32'd1 << OFFSET_BITS) - 32'd1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rline_q <= '0;
      wline_q <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.write_i) begin
            wline_q <= bus.line_i;
            addr_q  <= addr_d;
            cnt_q   <= '0;
            write_q <= 1'b1;
            state_q <= WR_BURST;
          end else if (bus.read_i) begin
            addr_q  <= addr_d;
            cnt_q   <= '0;
            read_q  <= 1'b1;
            state_q <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (bus.resp_i) begin
            rline_q[cnt_q*BURST_W +: BURST_W] <= bus.burst_i;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(BEATS - 1)) begin
              read_q  <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= RD_DONE;
            end
          end
        end
        WR_BURST: begin
          if (bus.resp_i) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(BEATS - 1)) begin
              write_q <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= WR_DONE;
            end
          end
        end
        RD_DONE: state_q <= IDLE;
        WR_DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write beat is selected straight from the latched line by the beat counter.
  assign bus.burst_o   = wline_q[cnt_q*BURST_W +: BURST_W];
  assign bus.line_o    = rline_q;
  assign bus.address_o = addr_q;
  assign bus.read_o    = read_q;
  assign bus.write_o   = write_q;
  assign bus.resp_o    = resp_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: reads, writes, gapped beats, collisions, reset abort.
module tb_cacheline_adaptor;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  cacheline_adaptor_if bus();

  cacheline_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [63:0]  rb [4];
  logic [63:0]  gb [4];
  logic [255:0] wline;
  logic [255:0] wline2;
  logic [255:0] exp_line;
  int           bi;
  int           gap_pat [7];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rb[0] = 64'h1111_1111_1111_1111;
    rb[1] = 64'h2222_2222_2222_2222;
    rb[2] = 64'h3333_3333_3333_3333;
    rb[3] = 64'h4444_4444_4444_4444;
    gb[0] = 64'hA0A0_A0A0_A0A0_A0A0;
    gb[1] = 64'hB1B1_B1B1_B1B1_B1B1;
    gb[2] = 64'hC2C2_C2C2_C2C2_C2C2;
    gb[3] = 64'hD3D3_D3D3_D3D3_D3D3;
    wline  = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
              64'h0F1E2D3C4B5A6978, 64'h8796A5B4C3D2E1F0};
    wline2 = {64'hDEAD_BEEF_0000_0004, 64'hDEAD_BEEF_0000_0003,
              64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001};
    gap_pat = '{1, 0, 0, 1, 0, 1, 1};

    rst           = 1'b0;
    bus.line_i    = '0;
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    step();
    step();
    chk("rst_read_o",  bus.read_o,    0);
    chk("rst_write_o", bus.write_o,   0);
    chk("rst_resp_o",  bus.resp_o,    0);
    chk("rst_addr_o",  bus.address_o, 0);
    chk("rst_line_o",  bus.line_o,    0);
    rst = 1'b1;
    step();

    // Plain read, back-to-back beats
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_1234;
    step();
    bus.read_i = 1'b0;
    chk("rd_read_o",  bus.read_o,    1);
    chk("rd_addr_o",  bus.address_o, 32'h0000_1220);
    chk("rd_resp_lo", bus.resp_o,    0);
    for (int b = 0; b < 4; b++) begin
      bus.burst_i = rb[b];
      bus.resp_i  = 1'b1;
      step();
      if (b < 3) begin
        chk("rd_resp_early", bus.resp_o, 0);
        chk("rd_read_hold",  bus.read_o, 1);
      end
    end
    bus.resp_i = 1'b0;
    chk("rd_resp_c5",  bus.resp_o, 1);
    chk("rd_read_off", bus.read_o, 0);
    chk("rd_line",     bus.line_o, {rb[3], rb[2], rb[1], rb[0]});
    step();
    chk("rd_resp_1cyc", bus.resp_o, 0);
    chk("rd_line_hold", bus.line_o, {rb[3], rb[2], rb[1], rb[0]});

    // Write
    bus.write_i   = 1'b1;
    bus.line_i    = wline;
    bus.address_i = 32'h00AB_CDEF;
    step();
    bus.write_i = 1'b0;
    bus.line_i  = '0;
    chk("wr_write_o", bus.write_o,   1);
    chk("wr_read_o",  bus.read_o,    0);
    chk("wr_addr_o",  bus.address_o, 32'h00AB_CDE0);
    chk("wr_beat0",   bus.burst_o,   wline[63:0]);
    for (int b = 0; b < 4; b++) begin
      bus.resp_i = 1'b1;
      step();
      if (b < 3) begin
        chk("wr_beat", bus.burst_o, wline[(b+1)*64 +: 64]);
        chk("wr_resp_early", bus.resp_o, 0);
      end
    end
    bus.resp_i = 1'b0;
    chk("wr_resp",      bus.resp_o,  1);
    chk("wr_write_off", bus.write_o, 0);
    chk("wr_rline_kept", bus.line_o, {rb[3], rb[2], rb[1], rb[0]});
    step();
    chk("wr_resp_1cyc", bus.resp_o, 0);

    // Read with gaps between beats
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_0040;
    step();
    bus.read_i = 1'b0;
    bi = 0;
    for (int k = 0; k < 7; k++) begin
      bus.resp_i  = gap_pat[k][0];
      bus.burst_i = (gap_pat[k] == 1) ? gb[bi] : 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      if (gap_pat[k] == 1) bi++;
      if (k < 6) begin
        chk("gap_resp_early", bus.resp_o, 0);
        chk("gap_read_hold",  bus.read_o, 1);
      end
    end
    bus.resp_i = 1'b0;
    chk("gap_resp", bus.resp_o, 1);
    chk("gap_line", bus.line_o, {gb[3], gb[2], gb[1], gb[0]});
    step();
    chk("gap_resp_1cyc", bus.resp_o, 0);

    // Simultaneous read and write: write wins, held read follows
    bus.read_i    = 1'b1;
    bus.write_i   = 1'b1;
    bus.line_i    = wline2;
    bus.address_i = 32'h0000_0100;
    step();
    bus.write_i = 1'b0;
    chk("sim_write_o", bus.write_o, 1);
    chk("sim_read_o",  bus.read_o,  0);
    chk("sim_beat0",   bus.burst_o, wline2[63:0]);
    for (int b = 0; b < 4; b++) begin
      bus.resp_i = 1'b1;
      step();
      if (b < 3) chk("sim_read_mid", bus.read_o, 0);
    end
    bus.resp_i = 1'b0;
    chk("sim_wr_resp",   bus.resp_o, 1);
    chk("sim_read_done", bus.read_o, 0);
    step();
    chk("sim_idle_read", bus.read_o, 0);
    step();
    bus.read_i = 1'b0;
    chk("sim_rd_start", bus.read_o, 1);
    for (int b = 0; b < 4; b++) begin
      bus.burst_i = rb[3-b];
      bus.resp_i  = 1'b1;
      step();
    end
    bus.resp_i = 1'b0;
    chk("sim_rd_resp", bus.resp_o, 1);
    chk("sim_rd_line", bus.line_o, {rb[0], rb[1], rb[2], rb[3]});
    step();

    // Reset in the middle of a read burst
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_0200;
    step();
    bus.read_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.burst_i = gb[b];
      bus.resp_i  = 1'b1;
      step();
    end
    bus.resp_i = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("abort_read_o", bus.read_o,    0);
    chk("abort_resp_o", bus.resp_o,    0);
    chk("abort_line_o", bus.line_o,    0);
    chk("abort_addr_o", bus.address_o, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("abort_no_resp", bus.resp_o, 0);
    end

    // Stray resp_i while idle must not advance anything
    bus.resp_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stray_resp_o", bus.resp_o, 0);
      chk("stray_read_o", bus.read_o, 0);
    end
    bus.resp_i = 1'b0;

    // Fresh read after reset and stray strobes
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_033F;
    step();
    bus.read_i = 1'b0;
    chk("post_addr_o", bus.address_o, 32'h0000_0320);
    for (int b = 0; b < 4; b++) begin
      bus.burst_i = gb[b];
      bus.resp_i  = 1'b1;
      step();
      if (b < 3) chk("post_resp_early", bus.resp_o, 0);
    end
    bus.resp_i = 1'b0;
    exp_line = {gb[3], gb[2], gb[1], gb[0]};
    chk("post_resp", bus.resp_o, 1);
    chk("post_line", bus.line_o, exp_line);
    step();
    chk("post_resp_1cyc", bus.resp_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 Parameters SHALL be: LINE_W, 256, cache line width in bits; BURST_W, 64, DRAM beat width in bits; BEATS, LINE_W/BURST_W (4), beats per line.
REQ-002 clk  input  1  rising-edge clock; the block SHALL use one clock only.
REQ-003 rst  input  1  reset, synchronous and active-low.
REQ-004 line_i  input  LINE_W  write-back line from the cache.
REQ-005 line_o  output  LINE_W  fill line to the cache.
REQ-006 address_i  input  32  cache request byte address.
REQ-007 read_i  input  1  cache line-read request (pmem_read).
REQ-008 write_i  input  1  cache line-write request (pmem_write).
REQ-009 resp_o  output  1  line transfer complete (pmem_resp).
REQ-010 burst_i  input  BURST_W  DRAM read beat.
REQ-011 burst_o  output  BURST_W  DRAM write beat.
REQ-012 address_o  output  32  DRAM line address.
REQ-013 read_o  output  1  DRAM burst read request.
REQ-014 write_o  output  1  DRAM burst write request.
REQ-015 resp_i  input  1  DRAM beat valid/accepted strobe.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE.
REQ-017 IDLE: with write_i=1, latch line_i and {address_i[31:5],5'b0}, clear the beat counter, and go to WR_BURST; otherwise, with read_i=1, latch the address, clear the counter, and go to RD_BURST.
REQ-018 Simultaneous read_i and write_i in IDLE SHALL select the write.
REQ-019 address_o SHALL carry the latched line-aligned address; low 5 bits SHALL always be 0.
REQ-020 RD_BURST: read_o=1; on each cycle with resp_i=1, capture burst_i into line_o[cnt*64 +: 64] (beat 0 = bits 63:0) and increment cnt.
REQ-021 RD_BURST SHALL go to RD_DONE on the cycle the 4th beat (cnt=3) is captured; read_o SHALL be 0 from the next cycle.
REQ-022 WR_BURST: write_o=1 and burst_o=latched_line[cnt*64 +: 64]; on each resp_i=1 increment cnt; the 4th beat moves to WR_DONE.
REQ-023 RD_DONE and WR_DONE SHALL assert resp_o=1 for exactly one cycle and then return to IDLE.
REQ-024 During RD_DONE, line_o SHALL hold the complete line, and it SHALL stay stable until the next read burst begins capturing.
REQ-025 resp_i SHALL be ignored in IDLE, RD_DONE and WR_DONE.
REQ-026 read_i and write_i SHALL be ignored outside IDLE, so the latched request is not affected by input changes mid-burst.
REQ-027 The beat counter SHALL be 2 bits and SHALL wrap from 3 to 0 only at burst end.
REQ-028 resp_i may have gaps between beats; each gap cycle SHALL hold cnt and the outputs unchanged.
REQ-029 Latency SHALL be: request accepted in cycle 0; with back-to-back beats, resp_o high in cycle 5 for both reads and writes.
REQ-030 resp_o SHALL never be asserted in the same cycle as read_o or write_o.

Reset
REQ-031 While rst=0 at a clock edge, the block SHALL enter IDLE and clear cnt.
REQ-032 While rst=0 at a clock edge, the block SHALL clear line_o, the latched line and address_o, and drive read_o, write_o and resp_o to 0.
REQ-033 Reset asserted mid-burst SHALL abort the transfer with no resp_o.
REQ-034 After reset releases, the first request SHALL be treated as new.

Structure
REQ-035 A shared package SHALL hold: the state enum type; constants LINE_W, BURST_W, BEATS and the OFFSET_BITS=5 used for address alignment.
REQ-036 The block SHALL be a single module with no sub-module; the beat-select shift and the capture logic SHALL be inline.

Verification
REQ-037 Read, no gaps: read_i=1, address_i=0x0000_1234; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> address_o=0x0000_1220; resp_o in cycle 5; line_o={0x44..,0x33..,0x22..,0x11..}.
REQ-038 Write: write_i=1, line_i=256'h0123...CDEF -> burst_o steps through bits 63:0, 127:64, 191:128, 255:192 on successive resp_i; resp_o pulses once.
REQ-039 Gapped beats: resp_i pattern 1,0,0,1,0,1,1 -> correct line assembled; resp_o exactly one cycle after the final beat.
REQ-040 Simultaneous read_i=write_i=1 -> write_o asserted, read_o stays 0; after completion, a held read_i starts a read burst.
REQ-041 Reset after 2 read beats -> outputs cleared next cycle and no resp_o; a subsequent read completes normally.
REQ-042 Stray resp_i=1 in IDLE -> no state change; cnt stays 0; no resp_o.
